rv32i_mem_arbiter: RTL and testbench

Shares one single-port unified memory between the pipeline's instruction-fetch port and its MEM-stage data port, which makes a von Neumann variant of the 5-stage RV32I core possible. Runs one transaction at a time through a request/grant/response handshake. Data accesses have priority, with an anti-starvation quota for fetch. Its fetch-valid output drives the pipeline's imem-valid enable, so the whole pipeline freezes while an access is pending.

---
 rtl/rv32i_mem_arbiter_pkg.sv | 24 ++
 rtl/rv32i_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_mem_arbiter_pkg.sv
// rv32i_mem_arbiter_pkg
// Shared types and constants for the unified-memory arbiter that lets the
// instruction-fetch port and the MEM-stage data port share one memory.
//   arb_state_t         : arbiter FSM state (also exported on the debug port)
//   arb_owner_t         : which port owns the in-flight memory transaction
//   ARB_MAX_DATA_STREAK : default number of back-to-back data grants allowed
//                         while a fetch is waiting
package rv32i_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_t;

  localparam int ARB_MAX_DATA_STREAK = 4;

endpackage

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter
// Shares one single-port memory between the fetch port (if_*) and the data
// port (d_*). One transaction at a time: IDLE picks a winner and latches its
// attributes, REQ presents them until mem_gnt_i, RESP waits for mem_rvalid_i.
// Data has priority; after MAX_DATA_STREAK data grants with fetch waiting,
// the next grant goes to fetch.
//
// Handshakes:
//   Port side : if_req_i / d_re_i / d_we_i are held by the requester until
//               the matching one-cycle completion pulse (if_valid_o,
//               d_done_o); a fetch may also be abandoned with if_flush_i.
//   Mem side  : mem_req_o stays high with stable mem_* until a cycle with
//               mem_gnt_i=1; the response is the first mem_rvalid_i=1 cycle
//               in RESP. mem_gnt_i outside REQ and mem_rvalid_i outside RESP
//               are ignored.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   if_req_i/if_addr_i/if_flush_i  fetch request, address, redirect flush
//   if_rdata_o/if_valid_o          fetched word, completion pulse
//   d_re_i/d_we_i/d_addr_i/d_wdata_i/d_be_i  load/store request
//   d_rdata_o/d_done_o             load data, completion pulse
//   mem_*                          memory request/response interface
//   dbg_state_o/dbg_owner_o        current FSM state and transaction owner
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_DATA_STREAK = ARB_MAX_DATA_STREAK
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_flush_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_valid_o,
  input  logic                d_re_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_done_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output arb_state_t          dbg_state_o,
  output arb_owner_t          dbg_owner_o
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t          state_q;
  arb_owner_t          owner_q;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                flush_pending_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic data_req, fetch_cand, fetch_wins, data_wins;

  // Winner selection, only acted on in IDLE. A flushed fetch is not a
  // candidate this cycle. A simultaneous load+store is handled as a store.
  always_comb begin
    data_req   = d_re_i | d_we_i;
    fetch_cand = if_req_i & ~if_flush_i;
    fetch_wins = fetch_cand & (~data_req | (streak_q == STREAK_MAX));
    data_wins  = data_req & ~fetch_wins;
  end

  // Streak counts data grants that overtook a waiting fetch; it resets as
  // soon as nobody is waiting on the fetch side, or fetch gets its turn.
  always_comb begin
    streak_d = streak_q;
    if (!if_req_i) begin
      streak_d = '0;
    end else if (state_q == ARB_IDLE) begin
      if (fetch_wins) begin
        streak_d = '0;
      end else if (data_wins && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ARB_IDLE;
      owner_q         <= OWN_NONE;
      streak_q        <= '0;
      flush_pending_q <= 1'b0;
      addr_q          <= '0;
      we_q            <= 1'b0;
      wdata_q         <= '0;
      be_q            <= '0;
    end else begin
      streak_q <= streak_d;
      case (state_q)
        ARB_IDLE: begin
          if (fetch_wins) begin
            owner_q <= OWN_IF;
            addr_q  <= if_addr_i;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
            state_q <= ARB_REQ;
          end else if (data_wins) begin
            owner_q <= OWN_D;
            addr_q  <= d_addr_i;
            we_q    <= d_we_i;
            wdata_q <= d_we_i ? d_wdata_i : '0;
            be_q    <= d_we_i ? d_be_i : '1;
            state_q <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          // The memory transaction is never aborted; a flushed fetch just
          // has its response dropped.
          if (if_flush_i && (owner_q == OWN_IF)) flush_pending_q <= 1'b1;
          if (mem_gnt_i) state_q <= ARB_RESP;
        end
        ARB_RESP: begin
          if (if_flush_i && (owner_q == OWN_IF)) flush_pending_q <= 1'b1;
          if (mem_rvalid_i) begin
            state_q         <= ARB_IDLE;
            owner_q         <= OWN_NONE;
            flush_pending_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          owner_q <= OWN_NONE;
        end
      endcase
    end
  end

  assign mem_req_o   = (state_q == ARB_REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  // A flush arriving in the same cycle as the response also suppresses it.
  assign if_valid_o = mem_rvalid_i & (state_q == ARB_RESP) & (owner_q == OWN_IF)
                    & ~flush_pending_q & ~if_flush_i;
  assign d_done_o   = mem_rvalid_i & (state_q == ARB_RESP) & (owner_q == OWN_D);
  assign if_rdata_o = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

  assign dbg_state_o = state_q;
  assign dbg_owner_o = owner_q;

`ifndef SYNTHESIS
  a_no_load_and_store: assert property (@(posedge clk_i) disable iff (reset_i)
    !(d_re_i && d_we_i));
`endif

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
module tb_rv32i_mem_arbiter;
  import rv32i_mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int W  = AW + 1;   // {we, addr} grant record

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic          reset_i;
  logic          if_req_i, if_flush_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_valid_o;
  logic          d_re_i, d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [BW-1:0] d_be_i;
  logic [DW-1:0] d_rdata_o;
  logic          d_done_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  arb_state_t    dbg_state_o;
  arb_owner_t    dbg_owner_o;

  rv32i_mem_arbiter dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .d_re_i(d_re_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
    .d_rdata_o(d_rdata_o), .d_done_o(d_done_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o), .dbg_owner_o(dbg_owner_o)
  );

  // ---------------- memory model ----------------
  // Drives at negedge: gnt after gnt_wait cycles of mem_req_o, rvalid the
  // cycle after gnt (unless held), plus an optional stray rvalid.
  int            gnt_wait = 0;
  logic          hold_rvalid = 1'b0;
  logic          force_rvalid = 1'b0;
  logic          gnt_given = 1'b0;
  int            wait_cnt = 0;
  logic [AW-1:0] resp_addr = '0;
  int            resp_cnt = 0;
  int            grant_cnt = 0;
  logic [W-1:0]  grant_val = '0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], 16'hC0DE};
  endfunction

  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b0;
    if (reset_i) begin
      gnt_given = 1'b0;
      wait_cnt  = 0;
    end else begin
      if (force_rvalid) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0_BAD0;
      end
      if (gnt_given && !hold_rvalid) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_data(resp_addr);
        gnt_given    = 1'b0;
        resp_cnt++;
      end
      if (mem_req_o && !gnt_given) begin
        if (wait_cnt >= gnt_wait) begin
          mem_gnt_i = 1'b1;
          gnt_given = 1'b1;
          wait_cnt  = 0;
          resp_addr = mem_addr_o;
          grant_val = {mem_we_o, mem_addr_o};
          grant_cnt++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int seen_grants = 0;
  int if_valid_cnt = 0, d_done_cnt = 0;
  int if_rem = 0, d_rem = 0;
  int last_if_cyc = 0, prev_if_cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle; observe at negedge+1 (after the memory model drove).
  // Requesters drop their request on completion once their count runs out.
  task automatic tick();
    @(negedge clk);
    #1;
    if (grant_cnt != seen_grants) begin
      seen_grants = grant_cnt;
      if (exp_q.size() == 0) check("grant_extra", {31'd0, grant_val}, 64'hFFFF_FFFF_FFFF_FFFF);
      else check("grant_order", {31'd0, grant_val}, {31'd0, exp_q.pop_front()});
    end
    if (if_valid_o) begin
      if_valid_cnt++;
      prev_if_cyc = last_if_cyc;
      last_if_cyc = cyc;
      check("if_rdata", {32'd0, if_rdata_o}, {32'd0, mem_data(if_addr_i)});
      if (if_rem > 0) if_rem--;
      if (if_rem == 0) if_req_i = 1'b0;
      else if_addr_i = if_addr_i + 32'd4;
    end
    if (d_done_o) begin
      d_done_cnt++;
      if (!d_we_i) check("d_rdata", {32'd0, d_rdata_o}, {32'd0, mem_data(d_addr_i)});
      if (d_rem > 0) d_rem--;
      if (d_rem == 0) begin
        d_re_i = 1'b0;
        d_we_i = 1'b0;
      end
      d_addr_i = d_addr_i + 32'd4;
    end
  endtask

  function automatic logic busy();
    return if_req_i | d_re_i | d_we_i | (dbg_state_o != ARB_IDLE);
  endfunction

  task automatic run_until_quiet(input string tag, input int budget);
    int k = 0;
    while (busy() && k < budget) begin
      tick();
      k++;
    end
    check(tag, {63'd0, busy()}, 64'd0);
    if (busy()) begin
      if_req_i = 1'b0;
      d_re_i   = 1'b0;
      d_we_i   = 1'b0;
    end
  endtask

  task automatic wait_state(input string tag, input arb_state_t st, input int budget);
    int k = 0;
    while (dbg_state_o != st && k < budget) begin
      tick();
      k++;
    end
    check(tag, {62'd0, dbg_state_o}, {62'd0, st});
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_req"},   {63'd0, mem_req_o},   64'd0);
    check({pfx, "_we"},    {63'd0, mem_we_o},    64'd0);
    check({pfx, "_addr"},  {32'd0, mem_addr_o},  64'd0);
    check({pfx, "_wdata"}, {32'd0, mem_wdata_o}, 64'd0);
    check({pfx, "_be"},    {60'd0, mem_be_o},    64'd0);
    check({pfx, "_ifv"},   {63'd0, if_valid_o},  64'd0);
    check({pfx, "_done"},  {63'd0, d_done_o},    64'd0);
    check({pfx, "_state"}, {62'd0, dbg_state_o}, {62'd0, ARB_IDLE});
    check({pfx, "_owner"}, {62'd0, dbg_owner_o}, {62'd0, OWN_NONE});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t0, v0, dn0, r0;
    reset_i = 1'b1;
    if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
    d_re_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;

    // Reset values
    tick(); tick();
    check_idle_outputs("rst");
    reset_i = 1'b0;
    tick();

    // Fetch only: two fetches from 0x100, latency 2, one access per 3 cycles
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b0, 32'h104});
    if_addr_i = 32'h100; if_req_i = 1'b1; if_rem = 2;
    t0 = cyc; v0 = if_valid_cnt;
    tick();
    check("f_req",  {63'd0, mem_req_o},  64'd1);
    check("f_addr", {32'd0, mem_addr_o}, 64'h100);
    check("f_we",   {63'd0, mem_we_o},   64'd0);
    check("f_be",   {60'd0, mem_be_o},   64'hF);
    run_until_quiet("f_quiet", 20);
    check("f_cnt",    if_valid_cnt - v0,         64'd2);
    check("f_lat",    prev_if_cyc - t0,          64'd2);
    check("f_period", last_if_cyc - prev_if_cyc, 64'd3);

    // Simultaneous fetch + store: store goes first
    exp_q.push_back({1'b1, 32'h2000});
    exp_q.push_back({1'b0, 32'h104});
    if_addr_i = 32'h104; if_req_i = 1'b1; if_rem = 1;
    d_addr_i = 32'h2000; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'hF; d_we_i = 1'b1; d_rem = 1;
    v0 = if_valid_cnt; dn0 = d_done_cnt;
    tick();
    check("s_we",    {63'd0, mem_we_o},    64'd1);
    check("s_addr",  {32'd0, mem_addr_o},  64'h2000);
    check("s_wdata", {32'd0, mem_wdata_o}, 64'hDEAD_BEEF);
    check("s_be",    {60'd0, mem_be_o},    64'hF);
    run_until_quiet("s_quiet", 20);
    check("s_done", d_done_cnt - dn0,   64'd1);
    check("s_ifv",  if_valid_cnt - v0,  64'd1);

    // Starvation: 6 loads vs one waiting fetch -> D,D,D,D,IF,D,D
    exp_q.push_back({1'b0, 32'h1000});
    exp_q.push_back({1'b0, 32'h1004});
    exp_q.push_back({1'b0, 32'h1008});
    exp_q.push_back({1'b0, 32'h100C});
    exp_q.push_back({1'b0, 32'h400});
    exp_q.push_back({1'b0, 32'h1010});
    exp_q.push_back({1'b0, 32'h1014});
    if_addr_i = 32'h400; if_req_i = 1'b1; if_rem = 1;
    d_addr_i = 32'h1000; d_re_i = 1'b1; d_rem = 6;
    v0 = if_valid_cnt; dn0 = d_done_cnt;
    run_until_quiet("st_quiet", 60);
    check("st_done", d_done_cnt - dn0,  64'd6);
    check("st_ifv",  if_valid_cnt - v0, 64'd1);

    // Flush while the fetch to 0x200 sits in RESP (gnt delayed 2 cycles)
    gnt_wait = 2; hold_rvalid = 1'b1;
    exp_q.push_back({1'b0, 32'h200});
    if_addr_i = 32'h200; if_req_i = 1'b1; if_rem = 1;
    v0 = if_valid_cnt; r0 = resp_cnt;
    wait_state("fl_in_resp", ARB_RESP, 10);
    if_flush_i = 1'b1; if_req_i = 1'b0;
    tick();
    if_flush_i = 1'b0; hold_rvalid = 1'b0;
    run_until_quiet("fl_quiet", 10);
    check("fl_mem_resp", resp_cnt - r0,     64'd1);
    check("fl_no_valid", if_valid_cnt - v0, 64'd0);
    gnt_wait = 0;

    // Next arbitration is normal
    exp_q.push_back({1'b0, 32'h204});
    if_addr_i = 32'h204; if_req_i = 1'b1; if_rem = 1;
    v0 = if_valid_cnt;
    run_until_quiet("fl2_quiet", 10);
    check("fl2_valid", if_valid_cnt - v0, 64'd1);

    // Flush in IDLE: the fetch is not arbitrated that cycle
    if_addr_i = 32'h208; if_req_i = 1'b1; if_rem = 1; if_flush_i = 1'b1;
    tick();
    check("fi_noreq", {63'd0, mem_req_o},   64'd0);
    check("fi_idle",  {62'd0, dbg_state_o}, {62'd0, ARB_IDLE});
    if_flush_i = 1'b0;
    exp_q.push_back({1'b0, 32'h208});
    v0 = if_valid_cnt;
    run_until_quiet("fi_quiet", 10);
    check("fi_valid", if_valid_cnt - v0, 64'd1);

    // Grant stall: 5 cycles of gnt low; latched outputs hold even if the
    // requester changes its inputs meanwhile
    gnt_wait = 5;
    exp_q.push_back({1'b1, 32'h3000});
    d_addr_i = 32'h3000; d_wdata_i = 32'h1234_5678; d_be_i = 4'h6; d_we_i = 1'b1; d_rem = 1;
    dn0 = d_done_cnt;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("g_req",   {63'd0, mem_req_o},   64'd1);
      check("g_we",    {63'd0, mem_we_o},    64'd1);
      check("g_addr",  {32'd0, mem_addr_o},  64'h3000);
      check("g_wdata", {32'd0, mem_wdata_o}, 64'h1234_5678);
      check("g_be",    {60'd0, mem_be_o},    64'h6);
      d_wdata_i = 32'hFFFF_FFFF;
      d_addr_i  = 32'h3100;
    end
    run_until_quiet("g_quiet", 10);
    check("g_done", d_done_cnt - dn0, 64'd1);
    gnt_wait = 0;

    // Reset while a load is in RESP, then a stray rvalid
    hold_rvalid = 1'b1;
    exp_q.push_back({1'b0, 32'h3800});
    d_addr_i = 32'h3800; d_re_i = 1'b1; d_rem = 1;
    v0 = if_valid_cnt; dn0 = d_done_cnt;
    wait_state("r_in_resp", ARB_RESP, 10);
    reset_i = 1'b1; d_re_i = 1'b0;
    tick();
    reset_i = 1'b0; hold_rvalid = 1'b0; force_rvalid = 1'b1;
    tick();
    check_idle_outputs("rr");
    force_rvalid = 1'b0;
    tick();
    check("rr_no_done", d_done_cnt - dn0,  64'd0);
    check("rr_no_ifv",  if_valid_cnt - v0, 64'd0);

    check("exp_q_left", exp_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
